// File: rtl/data_pack.sv
// ============================================================================
// Module      : data_pack
// Description : Groups 32-bit acquisition samples into byte-serial frames:
//               sync word, header, sequence number, timestamp, sample data,
//               then an 8-bit additive checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_pack #(
    parameter int SMP_PER_PKG = 32
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [31:0] ad_data,
    input  logic        ad_vld,
    input  logic        pk_en,
    input  logic [7:0]  dev_id,
    input  logic [7:0]  cfg_sample,
    input  logic [31:0] utc_sec,
    input  logic [31:0] now_ns,
    output logic [7:0]  pk_data,
    output logic        pk_vld,
    output logic        pk_frm,
    output logic [7:0]  cnt_drop
);

    // State reflects the phase of the byte currently shown on pk_data.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SUM  = 3'd4;

    localparam logic [7:0] C_SYNC0    = 8'hEB;
    localparam logic [7:0] C_SYNC1    = 8'h90;
    localparam logic [7:0] C_LAST_IDX = 8'(SMP_PER_PKG - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [31:0] utc_q, utc_d;
    logic [31:0] ns_q, ns_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  bcnt_q, bcnt_d;     // index of the next byte to load
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  pk_data_q, pk_data_d;
    logic        pk_vld_q, pk_vld_d;
    logic        pk_frm_q, pk_frm_d;
    logic [7:0]  drop_q, drop_d;

    logic        w_head_done;
    logic        w_data_done;
    logic        w_drop;
    logic [7:0]  w_hdr_byte;
    logic [7:0]  w_data_byte;

    assign w_head_done = (bcnt_q == 4'd13);
    assign w_data_done = (bcnt_q == 4'd4);
    assign w_drop      = ad_vld && ((state_q == S_HEAD) || (state_q == S_DATA) ||
                                    (state_q == S_SUM));

    // State register plus all datapath registers; reset abandons any frame.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= 32'h0;
            dev_q     <= 8'h0;
            cfg_q     <= 8'h0;
            utc_q     <= 32'h0;
            ns_q      <= 32'h0;
            idx_q     <= 8'h0;
            bcnt_q    <= 4'h0;
            seq_q     <= 8'h0;
            csum_q    <= 8'h0;
            pk_data_q <= 8'h0;
            pk_vld_q  <= 1'b0;
            pk_frm_q  <= 1'b0;
            drop_q    <= 8'h0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            dev_q     <= dev_d;
            cfg_q     <= cfg_d;
            utc_q     <= utc_d;
            ns_q      <= ns_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            seq_q     <= seq_d;
            csum_q    <= csum_d;
            pk_data_q <= pk_data_d;
            pk_vld_q  <= pk_vld_d;
            pk_frm_q  <= pk_frm_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ad_vld && pk_en) state_d = S_HEAD;
            S_HEAD: if (w_head_done)     state_d = S_DATA;
            S_DATA: if (w_data_done)     state_d = (idx_q == C_LAST_IDX) ? S_SUM : S_WAIT;
            S_WAIT: if (ad_vld)          state_d = S_DATA;
            S_SUM:                       state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Header byte selected by the byte counter (index 0 is loaded from IDLE).
    always_comb begin
        w_hdr_byte = 8'h00;
        case (bcnt_q)
            4'd1:    w_hdr_byte = C_SYNC1;
            4'd2:    w_hdr_byte = dev_q;
            4'd3:    w_hdr_byte = cfg_q;
            4'd4:    w_hdr_byte = seq_q;
            4'd5:    w_hdr_byte = utc_q[31:24];
            4'd6:    w_hdr_byte = utc_q[23:16];
            4'd7:    w_hdr_byte = utc_q[15:8];
            4'd8:    w_hdr_byte = utc_q[7:0];
            4'd9:    w_hdr_byte = ns_q[31:24];
            4'd10:   w_hdr_byte = ns_q[23:16];
            4'd11:   w_hdr_byte = ns_q[15:8];
            4'd12:   w_hdr_byte = ns_q[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // Held sample byte, MSB first, selected by the byte counter.
    always_comb begin
        case (bcnt_q[1:0])
            2'd0:    w_data_byte = hold_q[31:24];
            2'd1:    w_data_byte = hold_q[23:16];
            2'd2:    w_data_byte = hold_q[15:8];
            default: w_data_byte = hold_q[7:0];
        endcase
    end

    // Output and datapath next values; the loaded byte is shown next cycle.
    always_comb begin
        hold_d    = hold_q;
        dev_d     = dev_q;
        cfg_d     = cfg_q;
        utc_d     = utc_q;
        ns_d      = ns_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        seq_d     = seq_q;
        csum_d    = csum_q;
        pk_data_d = pk_data_q;
        pk_vld_d  = (state_d == S_HEAD) || (state_d == S_DATA) || (state_d == S_SUM);
        pk_frm_d  = (state_d != S_IDLE);
        drop_d    = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

        case (state_q)
            S_IDLE: begin
                if (ad_vld && pk_en) begin
                    hold_d    = ad_data;
                    dev_d     = dev_id;
                    cfg_d     = cfg_sample;
                    utc_d     = utc_sec;
                    ns_d      = now_ns;
                    idx_d     = 8'd0;
                    bcnt_d    = 4'd1;
                    csum_d    = 8'd0;
                    pk_data_d = C_SYNC0;
                end
            end
            S_HEAD: begin
                if (w_head_done) begin
                    pk_data_d = hold_q[31:24];
                    csum_d    = csum_q + hold_q[31:24];
                    bcnt_d    = 4'd1;
                end else begin
                    pk_data_d = w_hdr_byte;
                    bcnt_d    = bcnt_q + 4'd1;
                    // Sync bytes stay out of the checksum.
                    if (bcnt_q >= 4'd2) csum_d = csum_q + w_hdr_byte;
                end
            end
            S_DATA: begin
                if (!w_data_done) begin
                    pk_data_d = w_data_byte;
                    csum_d    = csum_q + w_data_byte;
                    bcnt_d    = bcnt_q + 4'd1;
                end else if (idx_q == C_LAST_IDX) begin
                    pk_data_d = csum_q;
                    seq_d     = seq_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (ad_vld) begin
                    hold_d    = ad_data;
                    idx_d     = idx_q + 8'd1;
                    bcnt_d    = 4'd1;
                    pk_data_d = ad_data[31:24];
                    csum_d    = csum_q + ad_data[31:24];
                end
            end
            default: ;
        endcase
    end

    assign pk_data  = pk_data_q;
    assign pk_vld   = pk_vld_q;
    assign pk_frm   = pk_frm_q;
    assign cnt_drop = drop_q;

endmodule

`default_nettype wire

// File: doc/data_pack.md
# data_pack

Framing stage directly upstream of the communication block. It collects 32-bit acquisition samples and wraps every SMP_PER_PKG of them into one byte-serial frame: sync word, device/config header, sequence number, and a UTC/ns timestamp latched at the frame's first sample. It drives the `pk_data`/`pk_vld`/`pk_frm` stream that the communication buffer consumes. Each frame ends with an 8-bit additive checksum.

## Interface
- SMP_PER_PKG, 32, samples per frame (1..255); frame length = 14 + 4·SMP_PER_PKG bytes.
- clk_sys  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ad_data  input  32  sample word, valid when ad_vld=1.
- ad_vld  input  1  one-cycle sample strobe.
- pk_en  input  1  packing enable, sampled only in IDLE.
- dev_id  input  8  device id, sampled at the frame's first sample.
- cfg_sample  input  8  sample-rate config code, sampled at the frame's first sample.
- utc_sec  input  32  UTC seconds, sampled at the frame's first sample.
- now_ns  input  32  nanoseconds within the second, sampled at the frame's first sample.
- pk_data  output  8  frame byte, registered.
- pk_vld  output  1  pk_data valid this cycle.
- pk_frm  output  1  high from the first sync byte through the checksum byte.
- cnt_drop  output  8  dropped-sample counter, saturates at 255.

## Operation
- States and transitions:
  - IDLE: on ad_vld && pk_en, do all of the following, then go to HEAD.
    - Latch ad_data into the hold register.
    - Latch dev_id, cfg_sample, utc_sec and now_ns.
    - Set sample index to 0 and byte counter to 0.
  - IDLE with ad_vld && !pk_en: ignore the sample; it is not counted as a drop.
  - HEAD: emit 13 bytes, one per cycle, in this order:
    - 0xEB, 0x90 (sync word)
    - dev_id, cfg_sample, seq
    - utc_sec[31:24], [23:16], [15:8], [7:0]
    - now_ns[31:24], [23:16], [15:8], [7:0]
    - Then go to DATA.
  - DATA: emit the hold register as 4 bytes, MSB first.
    - If index == SMP_PER_PKG−1, go to SUM; otherwise go to WAIT.
  - WAIT: pk_frm=1, pk_vld=0. On ad_vld, latch ad_data, increment index, go to DATA.
  - SUM: emit the checksum byte, increment seq (255 wraps to 0), go to IDLE.
- Checksum: 8-bit modulo-256 sum of every emitted byte from dev_id through the last sample byte. The sync bytes are excluded.
- Drops: an ad_vld arriving in HEAD, DATA or SUM is discarded and cnt_drop increments, holding at 255.
  - The sample currently held is unaffected.
  - Minimum sample spacing for lossless operation is 18 cycles.
- pk_en has no effect outside IDLE. A started frame always completes at full length; no truncation.
- dev_id, cfg_sample and the timestamp bytes come from the latched copies. Changes on these inputs mid-frame do not alter the frame.
- Reset (any time, including mid-frame):
  - State → IDLE.
  - pk_data=0x00, pk_vld=0, pk_frm=0.
  - seq=0, cnt_drop=0, checksum accumulator=0.
  - Any partial frame is abandoned.

## Timing
- ad_vld accepted in IDLE at cycle t:
  - pk_frm=1 and pk_vld=1 with 0xEB at t+1.
  - Header bytes occupy t+1..t+13.
  - First sample bytes occupy t+14..t+17.
- ad_vld accepted in WAIT at cycle u: that sample's 4 bytes appear at u+1..u+4.
- SUM byte appears the cycle after the last sample byte.
- pk_frm=0 the cycle after the SUM byte.
- pk_frm is low for at least 1 cycle between frames. An ad_vld on the cycle after SUM (state IDLE) starts a new frame.
- pk_vld is never high while pk_frm is low.
- pk_data holds its last value when pk_vld=0.
- cnt_drop updates the cycle after the dropped ad_vld.

## Test plan
- Basic frame, SMP_PER_PKG=2:
  - Stimulus: dev_id=0x05, cfg_sample=0x01, utc=0x00000001, ns=0x00000002; samples 0x11223344 then 0x55667788, 30 cycles apart.
  - Required: 22 bytes EB 90 05 01 00 00 00 00 01 00 00 00 02 11 22 33 44 55 66 77 88 6D.
  - Required: pk_frm high across all 22 bytes plus the WAIT gap, then low.
- Drop: second ad_vld 5 cycles after the first (in HEAD).
  - Required: sample discarded, cnt_drop=1, frame contents unchanged.
  - Required: 300 such drops leave cnt_drop=255.
- Sequence wrap: 257 consecutive frames.
  - Required: seq byte runs 0x00..0xFF, then 0x00; checksum correct for every frame.
- Enable gating:
  - pk_en=0 in IDLE with ad_vld: no output, cnt_drop unchanged.
  - pk_en dropped mid-frame: the frame completes at full length, and the next ad_vld starts no frame.
- Timestamp latch: change utc_sec/now_ns/dev_id during HEAD.
  - Required: frame carries the values present at the first-sample cycle.
- Reset mid-frame: assert rst_n=0 during DATA.
  - Required: outputs 0 immediately (asynchronous).
  - Required: after release, the next frame has seq=0x00 and a correct checksum.
